// File: rtl/fp_seq_normalizer.sv
// Sequential floating-point mantissa normalizer.
// Shifts an unnormalized mantissa left one bit per cycle until the hidden bit
// is set, the exponent reaches 1 (subnormal clamp) or the mantissa is zero.
module fp_seq_normalizer #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [MANT_W-1:0]          i_mant,
  input  logic [EXP_W-1:0]           i_exp,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [MANT_W-1:0]          o_mant,
  output logic [EXP_W-1:0]           o_exp,
  output logic [$clog2(MANT_W)-1:0]  o_shift_cnt,
  output logic                       o_zero,
  output logic                       o_denorm
);

  localparam int unsigned CNT_W = $clog2(MANT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q;
  logic [MANT_W-1:0]   mant_q;
  logic [EXP_W-1:0]    exp_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [MANT_W-1:0]   mant_d;
  logic [EXP_W-1:0]    exp_d;
  logic [CNT_W-1:0]    cnt_d;

  // Next values of the working registers for one normalization step.
  always_comb begin
    mant_d = {mant_q[MANT_W-2:0], 1'b0};
    exp_d  = exp_q - EXP_W'(1);
    cnt_d  = cnt_q + CNT_W'(1);
  end

  // Control FSM with working registers and registered result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_mant      <= '0;
      o_exp       <= '0;
      o_shift_cnt <= '0;
      o_zero      <= 1'b0;
      o_denorm    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            mant_q  <= i_mant;
            exp_q   <= i_exp;
            cnt_q   <= '0;
            o_busy  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (mant_q == '0) begin
            // Zero mantissa: canonical zero result.
            o_mant      <= '0;
            o_exp       <= '0;
            o_shift_cnt <= '0;
            o_zero      <= 1'b1;
            o_denorm    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
            state_q     <= DONE;
          end else if (mant_q[MANT_W-1]) begin
            // Hidden bit set: normal result, exponent passed through as-is.
            o_mant      <= mant_q;
            o_exp       <= exp_q;
            o_shift_cnt <= cnt_q;
            o_zero      <= 1'b0;
            o_denorm    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
            state_q     <= DONE;
          end else if (exp_q <= EXP_W'(1)) begin
            // Exponent exhausted before normalization: subnormal result.
            o_mant      <= mant_q;
            o_exp       <= '0;
            o_shift_cnt <= cnt_q;
            o_zero      <= 1'b0;
            o_denorm    <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
            state_q     <= DONE;
          end else begin
            mant_q <= mant_d;
            exp_q  <= exp_d;
            cnt_q  <= cnt_d;
          end
        end
        DONE: begin
          o_done  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_seq_normalizer.sv
// Directed self-checking bench for fp_seq_normalizer (MANT_W=24, EXP_W=8).
module tb_fp_seq_normalizer;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [23:0] i_mant;
  logic [7:0]  i_exp;
  logic        o_busy;
  logic        o_done;
  logic [23:0] o_mant;
  logic [7:0]  o_exp;
  logic [4:0]  o_shift_cnt;
  logic        o_zero;
  logic        o_denorm;

  int n_checks;
  int n_fail;

  fp_seq_normalizer #(.MANT_W(24), .EXP_W(8)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_mant      (i_mant),
    .i_exp       (i_exp),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_mant      (o_mant),
    .o_exp       (o_exp),
    .o_shift_cnt (o_shift_cnt),
    .o_zero      (o_zero),
    .o_denorm    (o_denorm)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Count one comparison and report it if it disagrees.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Check every result output against expected values.
  task automatic check_outs(input string tag, input logic [23:0] m, input logic [7:0] e,
                            input logic [4:0] c, input logic z, input logic d);
    check({tag, ".mant"},   32'(o_mant), 32'(m));
    check({tag, ".exp"},    32'(o_exp), 32'(e));
    check({tag, ".cnt"},    32'(o_shift_cnt), 32'(c));
    check({tag, ".zero"},   32'(o_zero), 32'(z));
    check({tag, ".denorm"}, 32'(o_denorm), 32'(d));
  endtask

  // Start one operation, expect o_done after exactly k+1 edges past E, check
  // results, then confirm return to IDLE and no second done pulse.
  // poke_at > 0 injects a second start (mant 0x800000) before edge E+poke_at.
  task automatic run_op(input string tag, input logic [23:0] m, input logic [7:0] e,
                        input int k, input int poke_at,
                        input logic [23:0] em, input logic [7:0] ee, input logic [4:0] ec,
                        input logic ez, input logic ed);
    int j;
    int dones;
    @(negedge i_clk);
    i_mant  = m;
    i_exp   = e;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_mant  = 24'h0;
    check({tag, ".busy_after_start"}, 32'(o_busy), 32'd1);
    j = 0;
    while (j < 40) begin
      if (poke_at > 0 && j + 1 == poke_at) begin
        i_start = 1'b1;
        i_mant  = 24'h800000;
      end
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_mant  = 24'h0;
      j++;
      if (o_done) break;
    end
    check({tag, ".done_edge"}, 32'(j), 32'(k + 1));
    check({tag, ".busy_in_done"}, 32'(o_busy), 32'd0);
    check_outs(tag, em, ee, ec, ez, ed);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk);
      #1;
      if (o_done) dones++;
    end
    check({tag, ".extra_done"}, 32'(dones), 32'd0);
    check({tag, ".busy_idle"}, 32'(o_busy), 32'd0);
    check_outs({tag, ".hold"}, em, ee, ec, ez, ed);
  endtask

  initial begin
    int dones;
    n_checks = 0;
    n_fail   = 0;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_mant   = 24'h0;
    i_exp    = 8'h0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst.busy", 32'(o_busy), 32'd0);
    check("rst.done", 32'(o_done), 32'd0);
    check_outs("rst", 24'h0, 8'h0, 5'd0, 1'b0, 1'b0);
    i_rst = 1'b0;

    // Already normal, accepted on the first edge after reset release.
    run_op("normal", 24'h800000, 8'h7F, 0, 0, 24'h800000, 8'h7F, 5'd0, 1'b0, 1'b0);
    // Maximum shift.
    run_op("maxshift", 24'h000001, 8'd100, 23, 0, 24'h800000, 8'd77, 5'd23, 1'b0, 1'b0);
    // Subnormal clamp.
    run_op("subnorm", 24'h000010, 8'd3, 2, 0, 24'h000040, 8'd0, 5'd2, 1'b0, 1'b1);
    // Zero input.
    run_op("zero", 24'h000000, 8'd50, 0, 0, 24'h000000, 8'd0, 5'd0, 1'b1, 1'b0);
    // MSB set with zero exponent stays normal.
    run_op("msb_exp0", 24'h800000, 8'd0, 0, 0, 24'h800000, 8'd0, 5'd0, 1'b0, 1'b0);
    // Exponent already 1: immediate subnormal, no shifts.
    run_op("exp1", 24'h000100, 8'd1, 0, 0, 24'h000100, 8'd0, 5'd0, 1'b0, 1'b1);
    // Generic case: 0x0F0000 needs 4 shifts.
    run_op("mid", 24'h0F0000, 8'd20, 4, 0, 24'hF00000, 8'd16, 5'd4, 1'b0, 1'b0);
    // Start while busy is ignored.
    run_op("busy_start", 24'h000001, 8'd100, 23, 3, 24'h800000, 8'd77, 5'd23, 1'b0, 1'b0);

    // Reset mid-operation at E+5 aborts with no done pulse.
    @(negedge i_clk);
    i_mant  = 24'h000001;
    i_exp   = 8'd100;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("abort.busy", 32'(o_busy), 32'd0);
    check("abort.done", 32'(o_done), 32'd0);
    check_outs("abort", 24'h0, 8'h0, 5'd0, 1'b0, 1'b0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge i_clk);
      #1;
      if (o_done || o_busy) dones++;
    end
    check("abort.no_activity", 32'(dones), 32'd0);
    run_op("after_abort", 24'h400000, 8'd10, 1, 0, 24'h800000, 8'd9, 5'd1, 1'b0, 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge i_clk);
    i_rst   = 1'b1;
    i_start = 1'b1;
    i_mant  = 24'h000001;
    i_exp   = 8'd100;
    @(posedge i_clk);
    #1;
    i_rst   = 1'b0;
    i_start = 1'b0;
    check("rst_prio.busy", 32'(o_busy), 32'd0);
    check("rst_prio.mant", 32'(o_mant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_seq_normalizer.md
FP_SEQ_NORMALIZER -- requirements
Module: fp_seq_normalizer

Interface
REQ-001 The block SHALL have parameter MANT_W, default 24, giving the mantissa width in bits (hidden bit included).
REQ-002 The block SHALL have parameter EXP_W, default 8, giving the biased exponent width in bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: port i_clk, input, 1 bit, rising-edge clock.
REQ-004 The block SHALL have port i_rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port i_start, input, 1 bit, a request to normalize i_mant/i_exp.
REQ-006 The block SHALL have port i_mant, input, MANT_W bits, the unnormalized mantissa.
REQ-007 The block SHALL have port i_exp, input, EXP_W bits, the biased exponent.
REQ-008 The block SHALL have port o_busy, output, 1 bit, high while in SHIFT.
REQ-009 The block SHALL have port o_done, output, 1 bit, a one-cycle result-valid pulse.
REQ-010 The block SHALL have port o_mant, output, MANT_W bits, the normalized mantissa.
REQ-011 The block SHALL have port o_exp, output, EXP_W bits, the adjusted exponent.
REQ-012 The block SHALL have port o_shift_cnt, output, $clog2(MANT_W) bits, the number of left shifts applied.
REQ-013 The block SHALL have port o_zero, output, 1 bit, high when the result mantissa is zero.
REQ-014 The block SHALL have port o_denorm, output, 1 bit, high when the result is subnormal.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE, when i_start=1, the block SHALL capture i_mant and i_exp into working registers, clear the shift count and enter SHIFT on the same edge.
REQ-017 i_start SHALL be ignored in SHIFT and in DONE; no queuing.
REQ-018 Each SHIFT cycle SHALL evaluate the working registers in this priority order:
- (a) mant==0 -> go to DONE with zero result.
- (b) mant[MANT_W-1]==1 -> go to DONE with a normal result.
- (c) exp<=1 -> go to DONE with a subnormal result.
- (d) otherwise, shift mant left by 1 with zero fill, decrement exp by 1, increment the count by 1, and stay in SHIFT.
REQ-019 Zero result SHALL drive o_mant=0, o_exp=0, o_zero=1, o_denorm=0 and o_shift_cnt=0.
REQ-020 Normal result SHALL drive the working mant, exp and count onto the outputs, with o_zero=0 and o_denorm=0.
REQ-021 Subnormal result SHALL drive o_mant=working mant, o_exp=0, o_denorm=1, o_zero=0 and o_shift_cnt=count.
REQ-022 An input with MSB=1 and i_exp=0 SHALL be treated as normal: outputs pass through unchanged with count 0.
REQ-023 Timing SHALL be as follows, with start sampled at edge E and k shifts needed:
- SHIFT occupies edges E..E+k.
- DONE is entered at edge E+k+1.
- o_done=1 for exactly the cycle between edges E+k+1 and E+k+2.
- IDLE is re-entered at edge E+k+2.
REQ-024 The maximum k SHALL be MANT_W-1; the count SHALL never wrap.
REQ-025 The exponent SHALL never decrement below 1 and SHALL never underflow or wrap.
REQ-026 o_mant, o_exp, o_shift_cnt, o_zero and o_denorm SHALL update only on entry to DONE and SHALL hold until the next DONE entry or reset.
REQ-027 o_busy SHALL be 1 exactly while the state is SHIFT.
REQ-028 o_done SHALL be 1 exactly while the state is DONE.
REQ-029 o_zero and o_denorm SHALL never be high simultaneously.

Reset
REQ-030 When i_rst=1 at a clock edge, the block SHALL enter IDLE and clear all of the following to 0: working registers, o_busy, o_done, o_mant, o_exp, o_shift_cnt, o_zero and o_denorm.
REQ-031 Reset SHALL take priority over i_start.
REQ-032 Reset during SHIFT or DONE SHALL abort the operation with no o_done pulse.
REQ-033 After reset releases, the block SHALL accept i_start on the first edge with i_rst=0.

Verification (MANT_W=24, EXP_W=8)
REQ-034 Already normal: i_mant=0x800000, i_exp=0x7F, start at E -> o_done during cycle E+1..E+2, o_mant=0x800000, o_exp=0x7F, cnt=0, zero=0, denorm=0.
REQ-035 Maximum shift: i_mant=0x000001, i_exp=100 -> 23 shifts, o_done during E+24..E+25, o_mant=0x800000, o_exp=77, cnt=23.
REQ-036 Subnormal clamp: i_mant=0x000010, i_exp=3 -> 2 shifts, o_mant=0x000040, o_exp=0, cnt=2, o_denorm=1.
REQ-037 Zero input: i_mant=0, i_exp=50 -> o_done at E+1, o_zero=1, o_exp=0, o_mant=0, cnt=0.
REQ-038 Reset mid-operation: i_mant=0x000001, i_exp=100, i_rst=1 at E+5 -> state IDLE, all outputs 0, no o_done. A following start of 0x400000 with exp 10 -> o_mant=0x800000, o_exp=9, cnt=1.
REQ-039 Start while busy: a second i_start pulse with i_mant=0x800000 during SHIFT of REQ-035 -> ignored, REQ-035 results unchanged, and exactly one o_done pulse.
